// File: rtl/sd_ctrl_fsm_p_if.sv
// -----------------------------------------------------------------------------
// sd_ctrl_fsm_p_if
// Bundles the control and engine-side signals of the SD bus controller FSM.
//   master : the controller FSM (consumes requests/engine status, drives commands)
//   slave  : top-level control plus cmd/data/OTP engines
// Signals:
//   istart, iabort, istart_blk, iend_blk            request side
//   icmd_done, iresp                                 command engine status
//   idata_crc_fail, idata_done, iotp_ready           data / OTP engine status
//   osel_clk, ogen_otp, onew_otp, ostart_cmd,
//   oindex, oarg, ostart_d                           engine control
//   obusy, oblk, osuccess, ofail, oerr               status
// -----------------------------------------------------------------------------
interface sd_ctrl_fsm_p_if #(
    parameter int ADDR_W = 23
) ();
    logic              istart;
    logic              iabort;
    logic [ADDR_W-1:0] istart_blk;
    logic [ADDR_W-1:0] iend_blk;
    logic              icmd_done;
    logic [31:0]       iresp;
    logic              idata_crc_fail;
    logic              idata_done;
    logic              iotp_ready;
    logic              osel_clk;
    logic              ogen_otp;
    logic              onew_otp;
    logic              ostart_cmd;
    logic [5:0]        oindex;
    logic [31:0]       oarg;
    logic              ostart_d;
    logic              obusy;
    logic [ADDR_W-1:0] oblk;
    logic              osuccess;
    logic              ofail;
    logic [2:0]        oerr;

    modport master (
        input  istart, iabort, istart_blk, iend_blk, icmd_done, iresp,
               idata_crc_fail, idata_done, iotp_ready,
        output osel_clk, ogen_otp, onew_otp, ostart_cmd, oindex, oarg, ostart_d,
               obusy, oblk, osuccess, ofail, oerr
    );

    modport slave (
        output istart, iabort, istart_blk, iend_blk, icmd_done, iresp,
               idata_crc_fail, idata_done, iotp_ready,
        input  osel_clk, ogen_otp, onew_otp, ostart_cmd, oindex, oarg, ostart_d,
               obusy, oblk, osuccess, ofail, oerr
    );
endinterface

// File: rtl/sd_ctrl_fsm_p.sv
// -----------------------------------------------------------------------------
// sd_ctrl_fsm_p
// SD bus controller FSM: card init (CMD55/ACMD41/CMD2/CMD3/CMD7/ACMD6), then
// read -> OTP -> write-back for every block in [istart_blk..iend_blk].
// Adds ACMD41 busy polling, bounded CRC retry, a response watchdog, abort and
// error reporting. The state code doubles as the command index on oindex.
// Ports:
//   iclk  clock
//   irst  asynchronous reset, active-high
//   bus   sd_ctrl_fsm_p_if master modport (requests, engine status, commands,
//         result flags and error code)
// -----------------------------------------------------------------------------
module sd_ctrl_fsm_p #(
    parameter int ADDR_W       = 23,
    parameter int ACMD41_TRIES = 255,
    parameter int CRC_RETRIES  = 3,
    parameter int TIMEOUT_W    = 20,
    parameter bit BUS4         = 1'b1
) (
    input logic            iclk,
    input logic            irst,
    sd_ctrl_fsm_p_if.master bus
);
    localparam int TRY_W = (ACMD41_TRIES < 2) ? 1 : $clog2(ACMD41_TRIES + 1);
    localparam int CRC_W = (CRC_RETRIES < 2) ? 1 : $clog2(CRC_RETRIES + 1);

    localparam logic [2:0] ERR_APP     = 3'd1;
    localparam logic [2:0] ERR_ACMD41  = 3'd2;
    localparam logic [2:0] ERR_BUSW    = 3'd3;
    localparam logic [2:0] ERR_CRC     = 3'd4;
    localparam logic [2:0] ERR_TIMEOUT = 3'd5;
    localparam logic [2:0] ERR_ABORT   = 3'd6;

    typedef enum logic [5:0] {
        IDLE   = 6'd0,  CMD55 = 6'd55, ACMD41 = 6'd41, CMD2  = 6'd2,
        CMD3   = 6'd3,  CMD7  = 6'd7,  ACMD6  = 6'd6,  CMD17 = 6'd17,
        READ   = 6'd19, CMD24 = 6'd24, WRITE  = 6'd20, CMD15 = 6'd15
    } state_t;

    state_t             state, state_next;
    logic [15:0]        rca;
    logic [TRY_W-1:0]   try_cnt;
    logic [CRC_W-1:0]   crc_cnt;
    logic [TIMEOUT_W-1:0] wdog;
    logic [ADDR_W-1:0]  end_blk, blk;
    logic               sel_clk, gen_otp, start_cmd, start_d;
    logic               success, fail;
    logic [2:0]         err;
    logic               data_done_s, otp_ready_s;

    logic               to_fail, to_ok, try_inc, crc_inc, blk_inc, rca_load, sel_set;
    logic [2:0]         fail_code;
    logic               changed;
    logic [22:0]        blk23;

    assign changed = (state_next != state);

    // next-state and transition side effects
    always_comb begin
        state_next = state;
        to_fail    = 1'b0;
        to_ok      = 1'b0;
        fail_code  = 3'd0;
        try_inc    = 1'b0;
        crc_inc    = 1'b0;
        blk_inc    = 1'b0;
        rca_load   = 1'b0;
        sel_set    = 1'b0;
        if (state != IDLE && bus.iabort) begin
            state_next = IDLE; to_fail = 1'b1; fail_code = ERR_ABORT;
        end else if (state != IDLE && wdog == '1) begin
            state_next = IDLE; to_fail = 1'b1; fail_code = ERR_TIMEOUT;
        end else begin
            case (state)
                IDLE: if (bus.istart) state_next = CMD55;
                CMD55: if (bus.icmd_done) begin
                    if (!bus.iresp[5]) begin
                        state_next = IDLE; to_fail = 1'b1; fail_code = ERR_APP;
                    end else begin
                        // second CMD55 (after CMD7) leads to bus-width selection
                        state_next = sel_clk ? ACMD6 : ACMD41;
                    end
                end
                ACMD41: if (bus.icmd_done) begin
                    if (!(bus.iresp[21] | bus.iresp[20])) begin
                        state_next = IDLE; to_fail = 1'b1; fail_code = ERR_ACMD41;
                    end else if (bus.iresp[31]) begin
                        state_next = CMD2;
                    end else if (32'(try_cnt) + 32'd1 >= 32'(ACMD41_TRIES)) begin
                        state_next = IDLE; to_fail = 1'b1; fail_code = ERR_ACMD41;
                    end else begin
                        state_next = CMD55; try_inc = 1'b1;
                    end
                end
                CMD2: if (bus.icmd_done) state_next = CMD3;
                CMD3: if (bus.icmd_done) begin
                    state_next = CMD7; rca_load = 1'b1; sel_set = 1'b1;
                end
                CMD7: if (bus.icmd_done) state_next = CMD55;
                ACMD6: if (bus.icmd_done) begin
                    if (bus.iresp[12:9] == 4'd4) begin
                        state_next = CMD17;
                    end else begin
                        state_next = IDLE; to_fail = 1'b1; fail_code = ERR_BUSW;
                    end
                end
                CMD17: if (bus.icmd_done) state_next = bus.iresp[31] ? CMD15 : READ;
                READ: begin
                    if (bus.idata_crc_fail) begin
                        if (32'(crc_cnt) < 32'(CRC_RETRIES)) begin
                            state_next = CMD17; crc_inc = 1'b1;
                        end else begin
                            state_next = IDLE; to_fail = 1'b1; fail_code = ERR_CRC;
                        end
                    end else if ((data_done_s | bus.idata_done) &&
                                 (otp_ready_s | bus.iotp_ready)) begin
                        state_next = CMD24;
                    end
                end
                CMD24: if (bus.icmd_done) state_next = WRITE;
                WRITE: if (bus.idata_done) begin
                    if (blk == end_blk) begin
                        state_next = CMD15;
                    end else begin
                        state_next = CMD17; blk_inc = 1'b1;
                    end
                end
                CMD15: if (bus.icmd_done) begin
                    state_next = IDLE; to_ok = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state       <= IDLE;
            rca         <= '0;
            try_cnt     <= '0;
            crc_cnt     <= '0;
            wdog        <= '0;
            end_blk     <= '0;
            blk         <= '0;
            sel_clk     <= 1'b0;
            gen_otp     <= 1'b0;
            start_cmd   <= 1'b0;
            start_d     <= 1'b0;
            success     <= 1'b0;
            fail        <= 1'b0;
            err         <= 3'd0;
            data_done_s <= 1'b0;
            otp_ready_s <= 1'b0;
        end else begin
            state     <= state_next;
            // pulses line up with the first cycle spent in the new state
            start_cmd <= changed && !(state_next inside {IDLE, READ, WRITE});
            start_d   <= changed && (state_next == CMD17 || state_next == WRITE);
            gen_otp   <= changed && (state_next == READ);
            wdog      <= (changed || state == IDLE) ? '0 : wdog + TIMEOUT_W'(1);
            data_done_s <= changed ? 1'b0 : (data_done_s | bus.idata_done);
            otp_ready_s <= changed ? 1'b0 : (otp_ready_s | bus.iotp_ready);
            if (state == IDLE && bus.istart) begin
                blk     <= bus.istart_blk;
                // an inverted range collapses to the single start block
                end_blk <= (bus.iend_blk < bus.istart_blk) ? bus.istart_blk : bus.iend_blk;
                success <= 1'b0;
                fail    <= 1'b0;
                err     <= 3'd0;
                try_cnt <= '0;
                crc_cnt <= '0;
            end
            if (try_inc)  try_cnt <= try_cnt + TRY_W'(1);
            if (crc_inc)  crc_cnt <= crc_cnt + CRC_W'(1);
            if (blk_inc) begin
                blk     <= blk + ADDR_W'(1);
                crc_cnt <= '0;
            end
            if (rca_load) rca <= bus.iresp[31:16];
            if (sel_set)  sel_clk <= 1'b1;
            if (state_next == IDLE) sel_clk <= 1'b0;
            if (to_fail) begin
                fail <= 1'b1;
                err  <= fail_code;
            end
            if (to_ok) success <= 1'b1;
        end
    end

    assign blk23 = 23'(blk);

    always_comb begin
        bus.oarg = 32'hFFFF_FFFF;
        case (state)
            CMD55:         bus.oarg = {sel_clk ? rca : 16'h0000, 16'hFFFF};
            ACMD41:        bus.oarg = 32'h8030_0000;
            CMD7, CMD15:   bus.oarg = {rca, 16'hFFFF};
            ACMD6:         bus.oarg = {30'b0, BUS4 ? 2'b10 : 2'b00};
            CMD17, CMD24:  bus.oarg = {blk23, 9'b0};
            default:       bus.oarg = 32'hFFFF_FFFF;
        endcase
    end

    assign bus.osel_clk   = sel_clk;
    assign bus.ogen_otp   = gen_otp;
    assign bus.onew_otp   = (state == IDLE);
    assign bus.ostart_cmd = start_cmd;
    assign bus.oindex     = state;
    assign bus.ostart_d   = start_d;
    assign bus.obusy      = (state != IDLE);
    assign bus.oblk       = blk;
    assign bus.osuccess   = success;
    assign bus.ofail      = fail;
    assign bus.oerr       = err;
endmodule

// File: tb/tb_sd_ctrl_fsm_p.sv
// -----------------------------------------------------------------------------
// tb_sd_ctrl_fsm_p
// Scoreboard bench for sd_ctrl_fsm_p. Each scenario pushes the hand-computed
// command sequence ({index, arg, osel_clk}) and final result
// ({osuccess, ofail, oerr}) into queues; a monitor pops and compares whenever
// the DUT pulses ostart_cmd or drops obusy. A responder task plays the card,
// data engine and OTP engine.
// -----------------------------------------------------------------------------
module tb_sd_ctrl_fsm_p;
    localparam int AW = 23;

    logic iclk = 1'b0;
    logic irst = 1'b1;
    always #5 iclk = ~iclk;

    sd_ctrl_fsm_p_if #(.ADDR_W(AW)) bus ();

    sd_ctrl_fsm_p #(
        .ADDR_W(AW), .ACMD41_TRIES(4), .CRC_RETRIES(3), .TIMEOUT_W(6), .BUS4(1'b1)
    ) dut (
        .iclk(iclk),
        .irst(irst),
        .bus (bus)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;
    logic [38:0] exp_q[$];
    logic [4:0]  res_q[$];

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic sel);
        exp_q.push_back({idx, arg, sel});
    endtask

    // busy = number of busy ACMD41 rounds before the card reports ready
    task automatic push_init(input int busy);
        for (int i = 0; i <= busy; i++) begin
            push_cmd(6'd55, 32'h0000_FFFF, 1'b0);
            push_cmd(6'd41, 32'h8030_0000, 1'b0);
        end
        push_cmd(6'd2,  32'hFFFF_FFFF, 1'b0);
        push_cmd(6'd3,  32'hFFFF_FFFF, 1'b0);
        push_cmd(6'd7,  32'h1234_FFFF, 1'b1);
        push_cmd(6'd55, 32'h1234_FFFF, 1'b1);
        push_cmd(6'd6,  32'h0000_0002, 1'b1);
    endtask

    task automatic check_reset(input string name);
        check(name,
              {bus.osel_clk, bus.ogen_otp, bus.onew_otp, bus.ostart_cmd, bus.oindex, bus.oarg,
               bus.ostart_d, bus.obusy, bus.oblk, bus.osuccess, bus.ofail, bus.oerr},
              {4'b0010, 6'd0, 32'hFFFF_FFFF, 2'b00, 23'd0, 2'b00, 3'd0});
    endtask

    // monitor: pops expectations whenever the DUT presents a command or finishes
    initial begin
        logic prev_busy;
        logic [38:0] e;
        logic [4:0]  r;
        prev_busy = 1'b0;
        forever begin
            @(posedge iclk);
            #1;
            if (bus.ostart_cmd) begin
                if (exp_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL unexpected_cmd: got idx %0d arg %h, none expected",
                             bus.oindex, bus.oarg);
                end else begin
                    e = exp_q.pop_front();
                    check("cmd", {bus.oindex, bus.oarg, bus.osel_clk}, e);
                end
            end
            if (prev_busy && !bus.obusy) begin
                if (res_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL unexpected_end: got %b/%b/%0d, none expected",
                             bus.osuccess, bus.ofail, bus.oerr);
                end else begin
                    r = res_q.pop_front();
                    check("result", {bus.osuccess, bus.ofail, bus.oerr}, r);
                end
            end
            prev_busy = bus.obusy;
        end
    end

    task automatic clear_pulses();
        bus.istart = 1'b0; bus.iabort = 1'b0; bus.icmd_done = 1'b0;
        bus.idata_crc_fail = 1'b0; bus.idata_done = 1'b0; bus.iotp_ready = 1'b0;
    endtask

    // Responder: starts a run, then answers every command/data request until idle.
    task automatic serve(input logic [AW-1:0] sblk, input logic [AW-1:0] eblk,
                         input int busy, input int crc_fails, input int oor_blk,
                         input int withhold, input bit abort_read, input bit rst_write,
                         input bit chk_restart);
        int busy_left = busy;
        int crc_left  = crc_fails;
        int cyc = 0;
        int c0  = -1;
        @(negedge iclk);
        bus.istart = 1'b1; bus.istart_blk = sblk; bus.iend_blk = eblk;
        @(negedge iclk);
        clear_pulses();
        if (chk_restart)
            check("restart", {bus.ofail, bus.oerr, bus.osel_clk, bus.oindex},
                  {1'b0, 3'd0, 1'b0, 6'd55});
        while (cyc < 500) begin
            if (!bus.obusy) break;
            if (bus.ostart_cmd && bus.oindex == 6'd2) c0 = cyc;
            if (bus.ostart_cmd && int'(bus.oindex) != withhold) begin
                bus.icmd_done = 1'b1;
                case (bus.oindex)
                    6'd55: bus.iresp = 32'h0000_0020;
                    6'd41: begin
                        if (busy_left > 0) begin
                            bus.iresp = 32'h0030_0000; busy_left--;
                        end else bus.iresp = 32'h8030_0000;
                    end
                    6'd3:  bus.iresp = 32'h1234_0000;
                    6'd6:  bus.iresp = 32'h0000_0800;
                    6'd17: bus.iresp = (int'(bus.oarg[31:9]) == oor_blk) ? 32'h8000_0000 : 32'h0;
                    default: bus.iresp = 32'h0;
                endcase
            end
            if (bus.ogen_otp) begin
                if (abort_read) begin
                    bus.iabort = 1'b1; bus.idata_done = 1'b1; bus.iotp_ready = 1'b1;
                end else if (crc_left > 0) begin
                    bus.idata_crc_fail = 1'b1; crc_left--;
                end else begin
                    bus.idata_done = 1'b1; bus.iotp_ready = 1'b1;
                end
            end
            if (bus.ostart_d && bus.oindex == 6'd20) begin
                if (rst_write) begin
                    irst = 1'b1;
                    #1;
                    check_reset("reset_mid_write");
                end else bus.idata_done = 1'b1;
            end
            @(negedge iclk);
            clear_pulses();
            cyc++;
        end
        if (cyc >= 500) begin
            chk_cnt++;
            $display("FAIL run_bound: still busy after %0d cycles, required idle", cyc);
            irst = 1'b1;
            @(negedge iclk);
            irst = 1'b0;
        end
        if (withhold != 0) begin
            chk_cnt++;
            if (c0 >= 0 && (cyc - c0) >= 63 && (cyc - c0) <= 65) pass_cnt++;
            else $display("FAIL timeout_window: got %0d cycles, required 63..65", cyc - c0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        clear_pulses();
        bus.istart_blk = '0; bus.iend_blk = '0; bus.iresp = '0;
        irst = 1'b1;
        repeat (3) @(negedge iclk);
        check_reset("reset_state");
        irst = 1'b0;
        @(negedge iclk);

        // happy path, blocks 5..7
        push_init(0);
        push_cmd(6'd17, 32'h0000_0A00, 1'b1); push_cmd(6'd24, 32'h0000_0A00, 1'b1);
        push_cmd(6'd17, 32'h0000_0C00, 1'b1); push_cmd(6'd24, 32'h0000_0C00, 1'b1);
        push_cmd(6'd17, 32'h0000_0E00, 1'b1); push_cmd(6'd24, 32'h0000_0E00, 1'b1);
        push_cmd(6'd15, 32'h1234_FFFF, 1'b1);
        res_q.push_back({1'b1, 1'b0, 3'd0});
        serve(23'd5, 23'd7, 0, 0, -1, 0, 1'b0, 1'b0, 1'b0);

        // card busy 3 rounds, ready on the 4th (last allowed); inverted range -> block 9 only
        push_init(3);
        push_cmd(6'd17, 32'h0000_1200, 1'b1); push_cmd(6'd24, 32'h0000_1200, 1'b1);
        push_cmd(6'd15, 32'h1234_FFFF, 1'b1);
        res_q.push_back({1'b1, 1'b0, 3'd0});
        serve(23'd9, 23'd3, 3, 0, -1, 0, 1'b0, 1'b0, 1'b0);

        // card busy forever -> exhausted after 4 rounds
        for (int i = 0; i < 4; i++) begin
            push_cmd(6'd55, 32'h0000_FFFF, 1'b0);
            push_cmd(6'd41, 32'h8030_0000, 1'b0);
        end
        res_q.push_back({1'b0, 1'b1, 3'd2});
        serve(23'd0, 23'd0, 100, 0, -1, 0, 1'b0, 1'b0, 1'b0);

        // 3 CRC failures then pass on block 0
        push_init(0);
        for (int i = 0; i < 4; i++) push_cmd(6'd17, 32'h0, 1'b1);
        push_cmd(6'd24, 32'h0, 1'b1);
        push_cmd(6'd15, 32'h1234_FFFF, 1'b1);
        res_q.push_back({1'b1, 1'b0, 3'd0});
        serve(23'd0, 23'd0, 0, 3, -1, 0, 1'b0, 1'b0, 1'b0);

        // 4 CRC failures -> fatal
        push_init(0);
        for (int i = 0; i < 4; i++) push_cmd(6'd17, 32'h0, 1'b1);
        res_q.push_back({1'b0, 1'b1, 3'd4});
        serve(23'd0, 23'd0, 0, 4, -1, 0, 1'b0, 1'b0, 1'b0);

        // CMD2 never answered -> watchdog
        push_cmd(6'd55, 32'h0000_FFFF, 1'b0);
        push_cmd(6'd41, 32'h8030_0000, 1'b0);
        push_cmd(6'd2,  32'hFFFF_FFFF, 1'b0);
        res_q.push_back({1'b0, 1'b1, 3'd5});
        serve(23'd0, 23'd0, 0, 0, -1, 2, 1'b0, 1'b0, 1'b0);

        // abort in READ together with idata_done
        push_init(0);
        push_cmd(6'd17, 32'h0, 1'b1);
        res_q.push_back({1'b0, 1'b1, 3'd6});
        serve(23'd0, 23'd0, 0, 0, -1, 0, 1'b1, 1'b0, 1'b0);

        // restart after abort: results cleared, slow clock, CMD55 first
        push_init(0);
        push_cmd(6'd17, 32'h0, 1'b1); push_cmd(6'd24, 32'h0, 1'b1);
        push_cmd(6'd15, 32'h1234_FFFF, 1'b1);
        res_q.push_back({1'b1, 1'b0, 3'd0});
        serve(23'd0, 23'd0, 0, 0, -1, 0, 1'b0, 1'b0, 1'b1);

        // out-of-range at block 3 of 2..4 ends the run early with success
        push_init(0);
        push_cmd(6'd17, 32'h0000_0400, 1'b1); push_cmd(6'd24, 32'h0000_0400, 1'b1);
        push_cmd(6'd17, 32'h0000_0600, 1'b1);
        push_cmd(6'd15, 32'h1234_FFFF, 1'b1);
        res_q.push_back({1'b1, 1'b0, 3'd0});
        serve(23'd2, 23'd4, 0, 0, 3, 0, 1'b0, 1'b0, 1'b0);

        // reset while in WRITE
        push_init(0);
        push_cmd(6'd17, 32'h0, 1'b1); push_cmd(6'd24, 32'h0, 1'b1);
        res_q.push_back({1'b0, 1'b0, 3'd0});
        serve(23'd0, 23'd1, 0, 0, -1, 0, 1'b0, 1'b1, 1'b0);
        @(negedge iclk);
        irst = 1'b0;

        repeat (5) @(negedge iclk);
        check("queues_empty", 80'(exp_q.size() + res_q.size()), 80'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
